// File: rtl/alu_acc_ctrl.sv
// Accumulator/sequencer wrapped around an external combinational add/sub stage.
// Accepts LOAD/ADD/SUB/CLR commands and returns acc plus flags over a valid/ready pair.
module alu_acc_ctrl #(
    parameter int WIDTH    = 4,
    parameter int STICKY_V = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_op,
    input  logic [WIDTH-1:0] as_s,
    input  logic             as_c,
    input  logic             as_v,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             ovf_sticky,
    output logic             res_valid,
    input  logic             res_ready
);

    // state | meaning
    // IDLE  | waiting for a command (cmd_ready high)
    // EXEC  | add/sub operands registered; capture its result this cycle
    // RESP  | result and flags presented (res_valid high) until res_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    state_t state;
    state_t state_next;
    logic   sticky_q;
    logic   is_arith;

    assign is_arith = (cmd_op == OP_ADD) || (cmd_op == OP_SUB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = is_arith ? EXEC : RESP;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            as_a     <= '0;
            as_b     <= '0;
            as_op    <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            flag_z   <= 1'b1;
            flag_n   <= 1'b0;
            sticky_q <= 1'b0;
        end else if (state == IDLE && cmd_valid) begin
            case (cmd_op)
                OP_LOAD: begin
                    acc    <= cmd_data;
                    flag_c <= 1'b0;
                    flag_v <= 1'b0;
                    flag_z <= (cmd_data == '0);
                    flag_n <= cmd_data[WIDTH-1];
                end
                OP_CLR: begin
                    acc      <= '0;
                    flag_c   <= 1'b0;
                    flag_v   <= 1'b0;
                    flag_z   <= 1'b1;
                    flag_n   <= 1'b0;
                    sticky_q <= 1'b0;
                end
                default: begin
                    as_a  <= acc;
                    as_b  <= cmd_data;
                    as_op <= cmd_op[1];
                end
            endcase
        end else if (state == EXEC) begin
            // adder is combinational from the registered operands, so its outputs are settled here
            acc      <= as_s;
            flag_c   <= as_c;
            flag_v   <= as_v;
            flag_z   <= (as_s == '0);
            flag_n   <= as_s[WIDTH-1];
            sticky_q <= sticky_q | as_v;
        end
    end

    assign ovf_sticky = (STICKY_V != 0) ? sticky_q : 1'b0;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Self-checking bench for alu_acc_ctrl: models the add/sub stage and checks results
// against an arithmetic reference of acc, flags and response latency.
module tb_alu_acc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'd0;
    logic [3:0] as_a, as_b, as_s;
    logic       as_op, as_c, as_v;
    logic [3:0] acc;
    logic       flag_c, flag_v, flag_z, flag_n, ovf_sticky;
    logic       res_valid;
    logic       res_ready = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [3:0] m_acc;
    logic       m_c, m_v, m_z, m_n, m_s;

    localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

    always #5 clk = ~clk;

    alu_acc_ctrl #(.WIDTH(4), .STICKY_V(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .as_a(as_a), .as_b(as_b), .as_op(as_op),
        .as_s(as_s), .as_c(as_c), .as_v(as_v),
        .acc(acc), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
        .ovf_sticky(ovf_sticky), .res_valid(res_valid), .res_ready(res_ready)
    );

    // Environment: the FourBitAddSub stage (two's-complement add of A and B or ~B+1)
    always_comb begin
        logic [4:0] t;
        logic [3:0] bb;
        bb   = as_op ? ~as_b : as_b;
        t    = {1'b0, as_a} + {1'b0, bb} + {4'b0, as_op};
        as_s = t[3:0];
        as_c = t[4];
        as_v = (as_a[3] == bb[3]) && (t[3] != as_a[3]);
    end

    function automatic logic [8:0] exp_vec();
        return {m_acc, m_c, m_v, m_z, m_n, m_s};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {acc, flag_c, flag_v, flag_z, flag_n, ovf_sticky};
    endfunction

    function automatic int to_signed4(input int x);
        return (x > 7) ? x - 16 : x;
    endfunction

    task automatic model_reset();
        m_acc = 4'd0; m_c = 0; m_v = 0; m_z = 1; m_n = 0; m_s = 0;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [3:0] d);
        int a, b, r, sr;
        a = int'(m_acc);
        b = int'(d);
        case (op)
            LOAD: begin
                m_acc = d; m_c = 0; m_v = 0; m_z = (b == 0); m_n = (b >= 8);
            end
            CLR: begin
                m_acc = 4'd0; m_c = 0; m_v = 0; m_z = 1; m_n = 0; m_s = 0;
            end
            default: begin
                if (op == ADD) begin
                    r  = a + b;
                    m_c = (r > 15);
                    sr = to_signed4(a) + to_signed4(b);
                end else begin
                    r  = a - b;
                    m_c = (a >= b);
                    sr = to_signed4(a) - to_signed4(b);
                end
                r = ((r % 16) + 16) % 16;
                m_acc = 4'(r);
                m_v = (sr > 7) || (sr < -8);
                m_z = (r == 0);
                m_n = (r >= 8);
                m_s = m_s | m_v;
            end
        endcase
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One full command transaction; hold = cycles of res_ready low once in RESP
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input int hold);
        logic [3:0] old_acc;
        int lat, exp_lat;
        @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_ready: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        res_ready = 1'($urandom_range(0, 1));
        old_acc = m_acc;
        @(posedge clk);
        model_cmd(op, d);
        exp_lat = (op == ADD || op == SUB) ? 2 : 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_data = 4'($urandom);
        lat = 1;
        if (op == ADD || op == SUB) begin
            compared++;
            if ({as_a, as_b, as_op} !== {old_acc, d, op[1]}) begin
                mismatched++;
                $display("FAIL operands: a/b/op=%h/%h/%b required %h/%h/%b",
                         as_a, as_b, as_op, old_acc, d, op[1]);
            end
            res_ready = 1'($urandom_range(0, 1));
        end else begin
            res_ready = 1'b0;
        end
        while (res_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            res_ready = 1'b0;
            lat++;
        end
        res_ready = 1'b0;
        compared++;
        if (res_valid !== 1'b1 || lat != exp_lat) begin
            mismatched++;
            $display("FAIL latency op=%0d: res_valid=%b after %0d cycles, required 1 after %0d",
                     op, res_valid, lat, exp_lat);
        end
        compared++;
        if (obs_vec() !== exp_vec() || cmd_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL result op=%0d d=%0d: acc,c,v,z,n,s=%b ready=%b required %b ready=0",
                     op, d, obs_vec(), cmd_ready, exp_vec());
        end
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 2'($urandom);
            cmd_data = 4'($urandom);
            @(negedge clk);
            compared++;
            if (obs_vec() !== exp_vec() || res_valid !== 1'b1 || cmd_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL hold cycle %0d: acc,c,v,z,n,s=%b valid=%b ready=%b required %b valid=1 ready=0",
                         i, obs_vec(), res_valid, cmd_ready, exp_vec());
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        compared++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || obs_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL complete: valid=%b ready=%b state=%b required valid=0 ready=1 state=%b",
                     res_valid, cmd_ready, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        compared++;
        if ({obs_vec(), res_valid, cmd_ready, as_a, as_b, as_op} !== {9'b0000_0_0_1_0_0, 1'b0, 1'b1, 9'b0}) begin
            mismatched++;
            $display("FAIL reset: acc,c,v,z,n,s=%b valid=%b ready=%b a=%h b=%h op=%b required 000000100 0 1 0 0 0",
                     obs_vec(), res_valid, cmd_ready, as_a, as_b, as_op);
        end
    endtask

    task automatic test_add_basic();
        do_cmd(LOAD, 4'd3, 0);
        do_cmd(ADD, 4'd4, 0);
        compared++;
        if ({acc, flag_c, flag_v, flag_z, flag_n} !== {4'd7, 4'b0000}) begin
            mismatched++;
            $display("FAIL add_3_4: acc=%0d cvzn=%b%b%b%b required acc=7 cvzn=0000",
                     acc, flag_c, flag_v, flag_z, flag_n);
        end
    endtask

    task automatic test_overflow();
        do_cmd(LOAD, 4'd10, 0);
        do_cmd(ADD, 4'd10, 0);
        do_cmd(LOAD, 4'd1, 0);
        compared++;
        if ({flag_v, ovf_sticky} !== 2'b01) begin
            mismatched++;
            $display("FAIL sticky_after_load: v=%b sticky=%b required v=0 sticky=1", flag_v, ovf_sticky);
        end
    endtask

    task automatic test_sub();
        do_cmd(LOAD, 4'd3, 0);
        do_cmd(SUB, 4'd4, 0);
        do_cmd(SUB, 4'd15, 0);
    endtask

    task automatic test_backpressure();
        do_cmd(ADD, 4'd5, 3);
        do_cmd(LOAD, 4'd8, 2);
    endtask

    task automatic test_reset_mid_exec();
        do_cmd(LOAD, 4'd9, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = ADD; cmd_data = 4'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (obs_vec() !== exp_vec() || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_mid_exec cycle %0d: acc,c,v,z,n,s=%b valid=%b ready=%b required %b valid=0 ready=1",
                         i, obs_vec(), res_valid, cmd_ready, exp_vec());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clr_after_overflow();
        do_cmd(LOAD, 4'd10, 0);
        do_cmd(ADD, 4'd10, 0);
        do_cmd(CLR, 4'($urandom), 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            do_cmd(2'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_basic();
        test_overflow();
        test_sub();
        test_backpressure();
        test_reset_mid_exec();
        test_clr_after_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
